// File: rtl/pwm_processeur_cpu_ocimem_arbiter.sv
// OCI debug-memory arbiter: shares one synchronous RAM between the JTAG
// debug path (pointer-based, single pending command) and the CPU Avalon
// debug slave, alternating priority whenever both sides compete.
module pwm_processeur_cpu_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rddata,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_done,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    JTAG_RD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_jptr;
  logic                r_pend_valid;
  logic                r_pend_wr;
  logic [31:0]         r_pend_data;
  logic                r_prio;
  logic [31:0]         r_mon;
  logic                r_done;
  logic                r_overrun;

  logic w_cpu_req;
  logic w_idle;
  logic w_grant_cpu;
  logic w_grant_jtag;
  logic w_str_a;
  logic w_str_b;
  logic w_str_n;
  logic w_lose;
  logic w_busy;
  logic w_a_ok;
  logic w_a_drop;
  logic w_fill;
  logic w_fill_drop;
  logic w_unused;

  // jdo bits outside the address/data fields carry no meaning here
  assign w_unused = &{1'b0, jdo[37:35], jdo[2:0]};

  // Request and grant decode; grants are suppressed while reset is held
  assign w_cpu_req    = cpu_read | cpu_write;
  assign w_idle       = (r_state == IDLE) & ~reset;
  assign w_grant_cpu  = w_idle & w_cpu_req & (~r_pend_valid | r_prio);
  assign w_grant_jtag = w_idle & r_pend_valid & (~w_cpu_req | ~r_prio);

  // Strobe priority: ocimem_a > ocimem_b > no_action_ocimem_a
  assign w_str_a = take_action_ocimem_a;
  assign w_str_b = take_action_ocimem_b & ~take_action_ocimem_a;
  assign w_str_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_lose  = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                 | (take_action_ocimem_b & take_no_action_ocimem_a);

  assign w_busy      = r_pend_valid | (r_state == JTAG_RD);
  assign w_a_ok      = w_str_a & ~w_busy;
  assign w_a_drop    = w_str_a & w_busy;
  assign w_fill      = (w_str_b | w_str_n) & (~r_pend_valid | w_grant_jtag);
  assign w_fill_drop = (w_str_b | w_str_n) & r_pend_valid & ~w_grant_jtag;

  assign jtag_busy    = w_busy;
  assign MonDReg      = r_mon;
  assign jtag_done    = r_done;
  assign jtag_overrun = r_overrun;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: reads take a second cycle for the RAM data
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_cpu && cpu_read)          w_state_nxt = CPU_RD;
        else if (w_grant_jtag && !r_pend_wr)  w_state_nxt = JTAG_RD;
      end
      CPU_RD:  w_state_nxt = IDLE;
      JTAG_RD: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: RAM port and Avalon response, all combinational
  always_comb begin
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    ram_addr        = '0;
    ram_wrdata      = '0;
    cpu_readdata    = '0;
    cpu_waitrequest = w_cpu_req;
    if (w_grant_cpu) begin
      ram_addr = cpu_address;
      if (cpu_write) begin
        ram_we          = 1'b1;
        ram_wrdata      = cpu_writedata;
        cpu_waitrequest = 1'b0;
      end else begin
        ram_re = 1'b1;
      end
    end else if (w_grant_jtag) begin
      ram_addr = r_jptr;
      if (r_pend_wr) begin
        ram_we     = 1'b1;
        ram_wrdata = r_pend_data;
      end else begin
        ram_re = 1'b1;
      end
    end
    if (r_state == CPU_RD && !reset) begin
      cpu_readdata    = ram_rddata;
      cpu_waitrequest = 1'b0;
    end
  end

  // Priority flag points at the loser of the most recent grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_prio <= 1'b0;
    else if (w_grant_cpu)  r_prio <= 1'b0;
    else if (w_grant_jtag) r_prio <= 1'b1;
  end

  // JTAG pending slot: refill allowed in the cycle it is granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_data  <= '0;
    end else if (w_fill) begin
      r_pend_valid <= 1'b1;
      r_pend_wr    <= w_str_b;
      r_pend_data  <= jdo[34:3];
    end else if (w_grant_jtag) begin
      r_pend_valid <= 1'b0;
    end
  end

  // JTAG address pointer: load when idle, advance after each access
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_jptr <= '0;
    else if (w_a_ok)                   r_jptr <= jdo[ADDR_W+2:3];
    else if (w_grant_jtag && r_pend_wr) r_jptr <= r_jptr + ADDR_W'(1);
    else if (r_state == JTAG_RD)       r_jptr <= r_jptr + ADDR_W'(1);
  end

  // JTAG read capture and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_grant_jtag & r_pend_wr) | (r_state == JTAG_RD);
      if (r_state == JTAG_RD) r_mon <= ram_rddata;
    end
  end

  // Sticky overrun: any dropped command sets it, an accepted pointer load clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_overrun <= 1'b0;
    else if (w_lose || w_a_drop || w_fill_drop) r_overrun <= 1'b1;
    else if (w_a_ok)                         r_overrun <= 1'b0;
  end

endmodule

// File: doc/pwm_processeur_cpu_ocimem_arbiter.md
# pwm_processeur_cpu_ocimem_arbiter

Sequences and shares the Nios II on-chip debug memory (OCI RAM) between two requesters: the JTAG debug path, which issues decoded action strobes and the 38-bit `jdo` word in the system-clock domain, and the CPU's Avalon debug-memory slave port. It sits between the debug-slave system-clock logic and a single-port synchronous RAM. It owns the auto-incrementing JTAG address pointer, captures JTAG read data into `MonDReg`, and enforces alternating priority so that neither side starves.

## Interface
Parameters:
- `ADDR_W`, default 8: OCI RAM word-address width; legal range 4..12.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  JTAG data word, valid in any cycle that carries a strobe.
- `take_action_ocimem_a`  in  1  load the JTAG address pointer from `jdo[ADDR_W+2:3]`.
- `take_action_ocimem_b`  in  1  queue a JTAG write of `jdo[34:3]` at the pointer.
- `take_no_action_ocimem_a`  in  1  queue a JTAG read at the pointer.
- `cpu_read`, `cpu_write`  in  1 each  Avalon requests; they are mutually exclusive.
- `cpu_address`  in  ADDR_W  CPU word address.
- `cpu_writedata`  in  32  CPU write data.
- `cpu_readdata`  out  32  CPU read data.
- `cpu_waitrequest`  out  1  Avalon wait.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wrdata`  out  32  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_re`  out  1  RAM read enable.
- `ram_rddata`  in  32  RAM read data, valid one cycle after `ram_re`.
- `MonDReg`  out  32  last JTAG read data.
- `jtag_busy`  out  1  a JTAG command is pending or in flight.
- `jtag_done`  out  1  one-cycle pulse when a JTAG access completes.
- `jtag_overrun`  out  1  sticky flag: a JTAG command was dropped.

## Operation
- Registered state:
  - FSM: `IDLE`, `CPU_RD`, `JTAG_RD`.
  - JTAG pointer `jptr` (ADDR_W bits).
  - JTAG pending slot: valid, type R/W, and 32-bit data.
  - `prio` flag: 0 = JTAG first, 1 = CPU first.
  - `MonDReg`, `jtag_done`, `jtag_overrun`.
- Strobe decode, when more than one strobe is high in a cycle: `ocimem_a` > `ocimem_b` > `no_action_ocimem_a`. The losing strobes are ignored and set `jtag_overrun`.
- `ocimem_a` loads `jptr`. It is accepted only when no JTAG command is pending or in flight; otherwise it is ignored and sets `jtag_overrun`. An accepted `ocimem_a` clears `jtag_overrun`.
- `ocimem_b` and `no_action_ocimem_a` fill the pending slot if the slot is empty or is being granted this cycle. If the slot is full and not being granted, the command is dropped and `jtag_overrun` is set.
- In `IDLE`, the candidates are the CPU request and the JTAG pending slot:
  - If both are present, the side named by `prio` wins. `prio` then points to the loser.
  - If only one is present, it wins and `prio` flips to the other side.
- CPU write grant:
  - `ram_we=1`, `ram_addr=cpu_address`, `ram_wrdata=cpu_writedata`, `cpu_waitrequest=0`.
  - FSM stays in `IDLE`.
- CPU read grant:
  - `ram_re=1`, `cpu_waitrequest=1`, go to `CPU_RD`.
  - In `CPU_RD`: `cpu_readdata=ram_rddata`, `cpu_waitrequest=0`, return to `IDLE`.
- JTAG write grant:
  - `ram_we=1` at `jptr` with the pending data.
  - Pending slot clears, `jptr` increments, `jtag_done` pulses next cycle.
- JTAG read grant:
  - `ram_re=1` at `jptr`, pending slot clears, go to `JTAG_RD`.
  - In `JTAG_RD`: `MonDReg` <= `ram_rddata`, `jptr` increments, `jtag_done` pulses next cycle, return to `IDLE`.
- `cpu_waitrequest=1` whenever a CPU request is present and not completing this cycle. This includes every cycle spent in `JTAG_RD`.
- `jptr` wraps from 2^ADDR_W-1 to 0. `cpu_readdata=0` outside `CPU_RD`.
- `jtag_busy` = pending valid OR state==`JTAG_RD`.
- RAM outputs are combinational from the FSM and grant: `ram_we`, `ram_re`, and `ram_addr` are 0 when nothing is granted.

## Timing
- Reset values:
  - FSM `IDLE`, `jptr=0`, pending empty, `prio=0`.
  - `MonDReg=0`, `jtag_done=0`, `jtag_overrun=0`.
  - `ram_we=0`, `ram_re=0`.
  - `cpu_waitrequest` = `cpu_read|cpu_write`.
- Reset mid-operation discards the pending slot and any in-flight read. A CPU master held in `CPU_RD` sees `cpu_waitrequest=1` until it is re-granted.
- Latencies with no contention:
  - CPU write: 1 cycle (no wait).
  - CPU read: 2 cycles (1 wait).
  - JTAG write: strobe at T, RAM write at T+1, `jtag_done` at T+2.
  - JTAG read: strobe at T, `ram_re` at T+1, `MonDReg` valid and `jtag_done` at T+3.
- Worst-case CPU wait behind JTAG is 2 cycles; alternation bounds each side to one grant before the other is served.
- A strobe arriving in the same cycle the pending slot is granted is accepted without overrun.

## Test plan
- Reset, then `ocimem_a` with `jdo[10:3]`=0x10, then `ocimem_b` with data 0xDEADBEEF, then `no_action_ocimem_a` after `ocimem_a` reloads 0x10 -> RAM[0x10]=0xDEADBEEF, `MonDReg`=0xDEADBEEF, `jtag_done` pulses twice, `jptr`=0x11.
- CPU write 0x12345678 to 0x05, then CPU read 0x05 -> write completes with 0 waits; read has 1 wait and returns 0x12345678.
- Continuous CPU reads with a JTAG write queued -> JTAG is granted on the first `IDLE` with `prio=0`. The next contention goes to the CPU; grants strictly alternate.
- `jptr`=0xFF, two JTAG writes -> data lands at 0xFF then 0x00; `jptr`=0x01.
- Two `ocimem_b` strobes on back-to-back cycles while the CPU owns the RAM -> second is dropped and `jtag_overrun`=1; a later accepted `ocimem_a` clears it.
- `reset` asserted during `JTAG_RD` -> `MonDReg`=0, no `jtag_done`, `jtag_busy`=0, FSM `IDLE`.
